// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency single-port memory between fetch and data ports
//
// Ports:
//   clk, rst_n                       clock (rising edge), asynchronous active-low reset
//   if_req/if_addr                   fetch request, held until if_ready
//   if_rdata/if_ready                fetched word and one-cycle completion pulse
//   dm_req/dm_we/dm_funct3/
//   dm_addr/dm_wdata                 data request (load or store), held until dm_ready
//   dm_rdata/dm_ready                load data and one-cycle completion pulse
//   mem_en/mem_we/mem_funct3/
//   mem_addr/mem_wdata               one-cycle memory strobe plus registered access fields
//   mem_rdata                        memory read data, valid MEM_LAT cycles after mem_en
//   busy                             high whenever an access is in progress
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic              owner_dm, owner_dm_nx;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_nx;
    logic [SC_W-1:0]   starve_cnt, starve_cnt_nx;
    logic              grant_dm;

    logic              mem_we_nx;
    logic [2:0]        mem_funct3_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic [DATA_W-1:0] if_rdata_nx, dm_rdata_nx;

    // Data normally wins; once fetch has watched STARVE_MAX data grants go by,
    // it gets the next slot.
    assign grant_dm = dm_req && !(if_req && (starve_cnt == SC_W'(STARVE_MAX)));

    always_comb begin
        state_nx      = state;
        owner_dm_nx   = owner_dm;
        lat_cnt_nx    = lat_cnt;
        starve_cnt_nx = starve_cnt;
        mem_we_nx     = mem_we;
        mem_funct3_nx = mem_funct3;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        if_rdata_nx   = if_rdata;
        dm_rdata_nx   = dm_rdata;

        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_nx    = ISSUE;
                    owner_dm_nx = grant_dm;
                    if (grant_dm) begin
                        mem_we_nx     = dm_we;
                        mem_funct3_nx = dm_funct3;
                        mem_addr_nx   = dm_addr;
                        mem_wdata_nx  = dm_wdata;
                    end else begin
                        mem_we_nx     = 1'b0;
                        mem_funct3_nx = 3'b010;
                        mem_addr_nx   = if_addr;
                        mem_wdata_nx  = '0;
                    end
                    // Count only data grants that actually made fetch wait.
                    if (grant_dm && if_req) begin
                        if (starve_cnt != SC_W'(STARVE_MAX)) begin
                            starve_cnt_nx = starve_cnt + SC_W'(1);
                        end
                    end else begin
                        starve_cnt_nx = '0;
                    end
                end
            end
            ISSUE: begin
                lat_cnt_nx = LAT_W'(MEM_LAT - 1);
                state_nx   = WAIT;
            end
            WAIT: begin
                if (lat_cnt != '0) begin
                    lat_cnt_nx = lat_cnt - LAT_W'(1);
                end else begin
                    state_nx = RESP;
                    // Stores leave the owner's read register untouched.
                    if (!mem_we) begin
                        if (owner_dm) begin
                            dm_rdata_nx = mem_rdata;
                        end else begin
                            if_rdata_nx = mem_rdata;
                        end
                    end
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so every output comes
    // straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_dm   <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            mem_we     <= 1'b0;
            mem_funct3 <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_en     <= 1'b0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            owner_dm   <= owner_dm_nx;
            lat_cnt    <= lat_cnt_nx;
            starve_cnt <= starve_cnt_nx;
            mem_we     <= mem_we_nx;
            mem_funct3 <= mem_funct3_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            if_rdata   <= if_rdata_nx;
            dm_rdata   <= dm_rdata_nx;
            mem_en     <= (state_nx == ISSUE);
            if_ready   <= (state_nx == RESP) && !owner_dm_nx;
            dm_ready   <= (state_nx == RESP) && owner_dm_nx;
            busy       <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int NI   = 4;
    localparam int SMAX = 4;
    localparam int LATS [NI] = '{1, 2, 3, 5};
    localparam int NCYC = 2000;

    logic        clk = 1'b0;
    logic        rst_n      [NI];
    logic        if_req     [NI];
    logic [31:0] if_addr    [NI];
    logic [31:0] if_rdata   [NI];
    logic        if_ready   [NI];
    logic        dm_req     [NI];
    logic        dm_we      [NI];
    logic [2:0]  dm_funct3  [NI];
    logic [31:0] dm_addr    [NI];
    logic [31:0] dm_wdata   [NI];
    logic [31:0] dm_rdata   [NI];
    logic        dm_ready   [NI];
    logic        mem_en     [NI];
    logic        mem_we     [NI];
    logic [2:0]  mem_funct3 [NI];
    logic [31:0] mem_addr   [NI];
    logic [31:0] mem_wdata  [NI];
    logic [31:0] mem_rdata  [NI];
    logic        busy       [NI];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(LATS[g]), .STARVE_MAX(SMAX)
        ) u_dut (
            .clk(clk), .rst_n(rst_n[g]),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ready(if_ready[g]),
            .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_funct3(dm_funct3[g]), .dm_addr(dm_addr[g]),
            .dm_wdata(dm_wdata[g]), .dm_rdata(dm_rdata[g]), .dm_ready(dm_ready[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_funct3(mem_funct3[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
    end

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    // Memory: data valid only in the cycle exactly MEM_LAT after mem_en, junk otherwise.
    int          cyc = 0;
    int          due  [NI];
    logic [31:0] dadr [NI];
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (mem_en[k]) begin
                due[k]  = cyc + LATS[k];
                dadr[k] = mem_addr[k];
            end
            mem_rdata[k] = (cyc == due[k]) ? memval(dadr[k]) : (32'hBAD00000 | 32'(cyc));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctl_of(input int k);
        return {24'b0, mem_en[k], mem_we[k], if_ready[k], dm_ready[k], busy[k], mem_funct3[k]};
    endfunction

    task automatic idle_inputs(input int k);
        if_req[k] = 0; if_addr[k] = 0; dm_req[k] = 0; dm_we[k] = 0;
        dm_funct3[k] = 0; dm_addr[k] = 0; dm_wdata[k] = 0;
    endtask

    task automatic new_fetch(input int k);
        if_req[k]  = 1;
        if_addr[k] = $urandom & 32'h0000FFFC;
    endtask

    task automatic new_data(input int k);
        dm_req[k]    = 1;
        dm_we[k]     = 1'($urandom_range(0, 1));
        dm_funct3[k] = 3'($urandom_range(0, 7));
        dm_addr[k]   = $urandom & 32'h0000FFFF;
        dm_wdata[k]  = $urandom;
    endtask

    typedef struct {
        logic        ifq;
        logic [31:0] ifa;
        logic        dmq;
        logic        dwe;
        logic [2:0]  df3;
        logic [31:0] dma;
        logic [31:0] dwd;
        logic [31:0] ctl;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [31:0] ifrd;
        logic [31:0] dmrd;
    } vec_t;

    function automatic vec_t v(
        input logic [31:0] ifq, ifa, dmq, dwe, df3, dma, dwd,
        input logic [31:0] en, we, ifr, dmr, bsy, mf3, maddr, mwd, ifrd, dmrd);
        vec_t s;
        s.ifq = ifq[0]; s.ifa = ifa; s.dmq = dmq[0]; s.dwe = dwe[0]; s.df3 = df3[2:0];
        s.dma = dma; s.dwd = dwd;
        s.ctl = {24'b0, en[0], we[0], ifr[0], dmr[0], bsy[0], mf3[2:0]};
        s.maddr = maddr; s.mwd = mwd; s.ifrd = ifrd; s.dmrd = dmrd;
        return s;
    endfunction

    // Behavioural reference: an abstract schedule per instance (arbitration cycle,
    // winner, fields) from which every output of every cycle is derived.
    int          arb_c [NI];
    int          idle_at [NI];
    int          st [NI];
    logic        own [NI];
    logic        nx_we [NI], e_we [NI];
    logic [2:0]  nx_f3 [NI], e_f3 [NI];
    logic [31:0] nx_addr [NI], nx_wd [NI], e_addr [NI], e_wd [NI];
    logic [31:0] e_ifr [NI], e_dmr [NI], pend [NI];

    vec_t        tbl [17];
    int          ng, en_at, en_n, rdy_at, rdy_n, seen, rc;
    logic [31:0] pat, rd, exp_ctl;
    logic        dwin;

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 0;
            idle_inputs(k);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset_ctl%0d", k), ctl_of(k), 0);
            chk($sformatf("reset_mem%0d", k), mem_addr[k] | mem_wdata[k], 0);
            chk($sformatf("reset_rdata%0d", k), if_rdata[k] | dm_rdata[k], 0);
            chk($sformatf("reset_starve%0d", k),
                (k == 0) ? 32'(g_dut[0].u_dut.starve_cnt) : 32'(g_dut[1].u_dut.starve_cnt), 0);
        end
        for (int k = 0; k < NI; k++) rst_n[k] = 1;
        @(negedge clk);

        // Directed table on instance 0 (MEM_LAT=1): fetch, store, simultaneous requests.
        tbl[0]  = v(1, 'h10, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = v(1, 'h10, 0, 0, 0, 0, 0,        1, 0, 0, 0, 1, 2, 'h10, 0, 0, 0);
        tbl[2]  = v(1, 'h10, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 2, 'h10, 0, 0, 0);
        tbl[3]  = v(0, 0, 0, 0, 0, 0, 0,           0, 0, 1, 0, 1, 2, 'h10, 0, 'hDEADBEEF, 0);
        tbl[4]  = v(0, 0, 1, 1, 0, 'h40, 'h5A,     0, 0, 0, 0, 0, 2, 'h10, 0, 'hDEADBEEF, 0);
        tbl[5]  = v(0, 0, 1, 1, 0, 'h40, 'h5A,     1, 1, 0, 0, 1, 0, 'h40, 'h5A, 'hDEADBEEF, 0);
        tbl[6]  = v(0, 0, 1, 1, 0, 'h40, 'h5A,     0, 1, 0, 0, 1, 0, 'h40, 'h5A, 'hDEADBEEF, 0);
        tbl[7]  = v(0, 0, 0, 0, 0, 0, 0,           0, 1, 0, 1, 1, 0, 'h40, 'h5A, 'hDEADBEEF, 0);
        tbl[8]  = v(1, 'h20, 1, 0, 4, 'h80, 'h77,  0, 1, 0, 0, 0, 0, 'h40, 'h5A, 'hDEADBEEF, 0);
        tbl[9]  = v(1, 'h20, 1, 0, 4, 'h80, 'h77,  1, 0, 0, 0, 1, 4, 'h80, 'h77, 'hDEADBEEF, 0);
        tbl[10] = v(1, 'h20, 1, 0, 4, 'h80, 'h77,  0, 0, 0, 0, 1, 4, 'h80, 'h77, 'hDEADBEEF, 0);
        tbl[11] = v(1, 'h20, 0, 0, 0, 0, 0,        0, 0, 0, 1, 1, 4, 'h80, 'h77, 'hDEADBEEF, memval('h80));
        tbl[12] = v(1, 'h20, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 4, 'h80, 'h77, 'hDEADBEEF, memval('h80));
        tbl[13] = v(1, 'h20, 0, 0, 0, 0, 0,        1, 0, 0, 0, 1, 2, 'h20, 0, 'hDEADBEEF, memval('h80));
        tbl[14] = v(1, 'h20, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 2, 'h20, 0, 'hDEADBEEF, memval('h80));
        tbl[15] = v(0, 0, 0, 0, 0, 0, 0,           0, 0, 1, 0, 1, 2, 'h20, 0, memval('h20), memval('h80));
        tbl[16] = v(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 2, 'h20, 0, memval('h20), memval('h80));
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("tbl%0d.ctl", i), ctl_of(0), tbl[i].ctl);
            chk($sformatf("tbl%0d.mem_addr", i), mem_addr[0], tbl[i].maddr);
            chk($sformatf("tbl%0d.mem_wdata", i), mem_wdata[0], tbl[i].mwd);
            chk($sformatf("tbl%0d.if_rdata", i), if_rdata[0], tbl[i].ifrd);
            chk($sformatf("tbl%0d.dm_rdata", i), dm_rdata[0], tbl[i].dmrd);
            if_req[0] = tbl[i].ifq; if_addr[0] = tbl[i].ifa;
            dm_req[0] = tbl[i].dmq; dm_we[0] = tbl[i].dwe; dm_funct3[0] = tbl[i].df3;
            dm_addr[0] = tbl[i].dma; dm_wdata[0] = tbl[i].dwd;
            @(negedge clk);
        end

        // Starvation: both held high -> D D D D F D.
        if_req[0] = 1; if_addr[0] = 32'h100;
        dm_req[0] = 1; dm_we[0] = 0; dm_funct3[0] = 3'b010; dm_addr[0] = 32'h200;
        ng = 0; pat = 0;
        for (int c = 0; c < 100 && ng < 6; c++) begin
            @(negedge clk);
            if (mem_en[0]) begin
                if (mem_addr[0] == 32'h100) begin
                    pat[ng] = 1'b1;
                    chk("starve_cnt_after_fetch", 32'(g_dut[0].u_dut.starve_cnt), 0);
                end
                ng++;
            end
        end
        chk("starve_grants", 32'(ng), 6);
        chk("starve_pattern", pat, 32'b010000);
        idle_inputs(0);
        for (int c = 0; c < 20 && busy[0]; c++) @(negedge clk);
        chk("starve_drain", 32'(busy[0]), 0);

        // Async reset during WAIT on instance 2 (MEM_LAT=3).
        if_req[2] = 1; if_addr[2] = 32'h30;
        repeat (3) @(negedge clk);
        chk("rst_in_wait_busy", 32'(busy[2]), 1);
        #2 rst_n[2] = 0;
        #1;
        chk("rst_now_ctl", ctl_of(2), 0);
        chk("rst_now_mem", mem_addr[2] | mem_wdata[2], 0);
        chk("rst_now_rdata", if_rdata[2] | dm_rdata[2], 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (if_ready[2] || mem_en[2] || busy[2]) seen++;
        end
        chk("rst_hold_quiet", 32'(seen), 0);
        rst_n[2] = 1;
        en_at = -1; en_n = 0; rdy_at = -1; rdy_n = 0; rd = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_en[2]) begin en_n++; en_at = c; end
            if (if_ready[2]) begin rdy_n++; rdy_at = c; rd = if_rdata[2]; if_req[2] = 0; end
        end
        chk("rst_regrant_en_at", 32'(en_at), 1);
        chk("rst_regrant_en_cnt", 32'(en_n), 1);
        chk("rst_regrant_rdy_at", 32'(rdy_at), 32'(LATS[2] + 2));
        chk("rst_regrant_rdy_cnt", 32'(rdy_n), 1);
        chk("rst_regrant_rdata", rd, memval(32'h30));

        // Random traffic on every latency, checked against the schedule model.
        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 0;
            idle_inputs(k);
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1;
            arb_c[k] = -100; idle_at[k] = 0; st[k] = 0; own[k] = 0;
            nx_we[k] = 0; nx_f3[k] = 0; nx_addr[k] = 0; nx_wd[k] = 0;
            e_we[k] = 0; e_f3[k] = 0; e_addr[k] = 0; e_wd[k] = 0;
            e_ifr[k] = 0; e_dmr[k] = 0; pend[k] = 0;
        end
        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                rc = arb_c[k] + 2 + LATS[k];
                if (n == arb_c[k] + 1) begin
                    e_addr[k] = nx_addr[k]; e_we[k] = nx_we[k]; e_f3[k] = nx_f3[k]; e_wd[k] = nx_wd[k];
                end
                if (n == rc && !e_we[k]) begin
                    if (own[k]) e_dmr[k] = pend[k];
                    else        e_ifr[k] = pend[k];
                end
                exp_ctl = {24'b0, (n == arb_c[k] + 1), e_we[k], (n == rc) && !own[k],
                           (n == rc) && own[k], (n > arb_c[k]) && (n < idle_at[k]), e_f3[k]};
                chk($sformatf("rnd%0d.ctl@%0d", k, n), ctl_of(k), exp_ctl);
                chk($sformatf("rnd%0d.mem_addr@%0d", k, n), mem_addr[k], e_addr[k]);
                chk($sformatf("rnd%0d.mem_wdata@%0d", k, n), mem_wdata[k], e_wd[k]);
                chk($sformatf("rnd%0d.if_rdata@%0d", k, n), if_rdata[k], e_ifr[k]);
                chk($sformatf("rnd%0d.dm_rdata@%0d", k, n), dm_rdata[k], e_dmr[k]);

                if (if_req[k]) begin
                    if (if_ready[k] || $urandom_range(0, 39) == 0) begin
                        if ($urandom_range(0, 1) == 1) new_fetch(k);
                        else if_req[k] = 0;
                    end
                end else if ($urandom_range(0, 2) == 0) new_fetch(k);
                if (dm_req[k]) begin
                    if (dm_ready[k] || $urandom_range(0, 39) == 0) begin
                        if ($urandom_range(0, 1) == 1) new_data(k);
                        else dm_req[k] = 0;
                    end
                end else if ($urandom_range(0, 1) == 0) new_data(k);

                if (n >= idle_at[k] && (if_req[k] || dm_req[k])) begin
                    dwin = dm_req[k] && !(if_req[k] && st[k] == SMAX);
                    st[k] = (dwin && if_req[k]) ? ((st[k] < SMAX) ? st[k] + 1 : SMAX) : 0;
                    own[k] = dwin;
                    nx_addr[k] = dwin ? dm_addr[k] : if_addr[k];
                    nx_we[k]   = dwin ? dm_we[k] : 1'b0;
                    nx_f3[k]   = dwin ? dm_funct3[k] : 3'b010;
                    nx_wd[k]   = dwin ? dm_wdata[k] : 32'h0;
                    pend[k]    = memval(nx_addr[k]);
                    arb_c[k]   = n;
                    idle_at[k] = n + 3 + LATS[k];
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
